rom_stream_rx: RTL and testbench

Byte-stream source and serial sink for the UART loopback design. A ROM holds 2^ADDR_WIDTH bytes. An address fetcher steps through the ROM on each `next` request. An 8N1 UART receiver decodes the serial `line` back into parallel bytes. The transmitter drives `next` with its ready strobe, consumes `rom_data`, and its tx line feeds `line`.

---
 rtl/rom_stream_rx_pkg.sv | 22 ++
 rtl/rom_stream_rx_if.sv | 25 ++
 rtl/rom_stream_rx_uart_rx_core.sv | 121 ++++++++++++
 rtl/rom_stream_rx.sv | 47 ++++
 tb/tb_rom_stream_rx.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_stream_rx_pkg.sv
// Shared definitions for the ROM byte source and UART receive path.
package rom_stream_rx_pkg;

   // Receiver FSM encoding
   typedef logic [1:0] rx_state_t;
   localparam rx_state_t StIdle  = 2'd0;
   localparam rx_state_t StStart = 2'd1;
   localparam rx_state_t StData  = 2'd2;
   localparam rx_state_t StStop  = 2'd3;

   // Clock cycles per serial bit, integer division
   function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                input int unsigned baudrate);
      return clk_freq / baudrate;
   endfunction

   // ROM image: ASCII '0' upwards; caller truncates to the word width
   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return 32'h30 + a;
   endfunction

endpackage

// File: rtl/rom_stream_rx_if.sv
// Bundle of fetch and serial-receive signals shared by source and sink.
interface rom_stream_rx_if #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 8
);
   logic                  next;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] rom_data;
   logic                  line;
   logic [DATA_WIDTH-1:0] receive_data;
   logic                  ready;
   logic                  frame_err;

   // Driver of next/line (transmitter side)
   modport master (
      output next, line,
      input  addr, rom_data, receive_data, ready, frame_err
   );

   // The rom_stream_rx block itself
   modport slave (
      input  next, line,
      output addr, rom_data, receive_data, ready, frame_err
   );
endinterface

// File: rtl/rom_stream_rx_uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchronizer, framing FSM, shift register.
module uart_rx_core
   import rom_stream_rx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter int unsigned DATA_WIDTH   = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  line,
   output logic [DATA_WIDTH-1:0] receive_data,
   output logic                  ready,
   output logic                  frame_err
);

   localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
   localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   logic                  sync1_q, line_s_q;
   rx_state_t             state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  armed_q, armed_d;
   logic                  ready_q, ready_d;
   logic                  ferr_q, ferr_d;

   // Two-flop synchronizer; resets to the idle-high level
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q  <= 1'b1;
         line_s_q <= 1'b1;
      end else begin
         sync1_q  <= line;
         line_s_q <= sync1_q;
      end
   end

   // Next-state logic for framing, bit timing and strobes
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      // A line held low out of reset must not be taken as a start bit
      armed_d = armed_q | line_s_q;
      ready_d = 1'b0;
      ferr_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (armed_q && !line_s_q) state_d = StStart;
         end
         StStart: begin
            if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = line_s_q ? StIdle : StData;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StData: begin
            if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
               cnt_d   = '0;
               shift_d = {line_s_q, shift_q[DATA_WIDTH-1:1]};
               if (idx_q == IDX_W'(DATA_WIDTH - 1)) state_d = StStop;
               else                                 idx_d   = idx_q + 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StStop: begin
            if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
               cnt_d   = '0;
               state_d = StIdle;
               if (line_s_q) begin
                  data_d  = shift_q;
                  ready_d = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Receiver state registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         armed_q <= 1'b0;
         ready_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         armed_q <= armed_d;
         ready_q <= ready_d;
         ferr_q  <= ferr_d;
      end
   end

   assign receive_data = data_q;
   assign ready        = ready_q;
   assign frame_err    = ferr_q;

endmodule

// File: rtl/rom_stream_rx.sv
// Byte-stream ROM source with address fetcher, plus UART receive sink.
module rom_stream_rx
   import rom_stream_rx_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 38400,
   parameter int unsigned BAUDRATE   = 9600,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 8
) (
   input logic            clk,
   input logic            rst_n,
   rom_stream_rx_if.slave bus
);

   localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUDRATE);

   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] rom_data_q;

   // Fetch address advances on every cycle with next high, wrapping naturally
   always_ff @(posedge clk) begin
      if (!rst_n) addr_q <= '0;
      else if (bus.next) addr_q <= addr_q + 1'b1;
   end

   // Registered ROM read of the current address
   always_ff @(posedge clk) begin
      if (!rst_n) rom_data_q <= '0;
      else        rom_data_q <= DATA_WIDTH'(rom_word(32'(addr_q)));
   end

   assign bus.addr     = addr_q;
   assign bus.rom_data = rom_data_q;

   uart_rx_core #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .DATA_WIDTH   (DATA_WIDTH)
   ) u_rx (
      .clk          (clk),
      .rst_n        (rst_n),
      .line         (bus.line),
      .receive_data (bus.receive_data),
      .ready        (bus.ready),
      .frame_err    (bus.frame_err)
   );

endmodule

// File: tb/tb_rom_stream_rx.sv
// Self-checking bench for rom_stream_rx: fetcher, ROM and UART receiver.
module tb_rom_stream_rx;

   localparam int unsigned CLK_FREQ = 38400;
   localparam int unsigned BAUDRATE = 9600;
   localparam int CPB  = CLK_FREQ / BAUDRATE;
   localparam int HALF = CPB / 2;
   localparam int STROBE_OFS = 2 + HALF + 9 * CPB;  // E0 to strobe-register edge
   localparam int DEPTH = 32;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;

   int          rdy_cyc[$];
   logic [7:0]  rdy_dat[$];
   int          ferr_cyc[$];

   rom_stream_rx_if bus ();

   rom_stream_rx dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every strobe with the edge index that registered it
   always @(posedge clk) begin
      #1;
      if (bus.ready === 1'b1) begin
         rdy_cyc.push_back(cyc);
         rdy_dat.push_back(bus.receive_data);
      end
      if (bus.frame_err === 1'b1) ferr_cyc.push_back(cyc);
   end

   task automatic clear_log();
      rdy_cyc.delete();
      rdy_dat.delete();
      ferr_cyc.delete();
   endtask

   // Serialize start, LSB-first data, stop; e0 is the first edge that sees line low
   task automatic send_frame(input logic [7:0] data, input logic stop, output int e0);
      logic [9:0] bits;
      bits = {stop, data, 1'b0};
      e0 = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus.line = bits[i];
         for (int j = 0; j < CPB; j++) begin
            @(posedge clk);
            if (i == 0 && j == 0) begin
               #1;
               e0 = cyc;
            end
         end
      end
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      bus.line = 1'b1;
      repeat (n) @(posedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.line = 1'b1;
      bus.next = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      if (bus.addr !== 5'd0) begin
         n_fail++; $display("FAIL reset_addr got=%h want=%h", bus.addr, 5'd0);
      end
      n_cmp++;
      if (bus.ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_ready got=%b want=0", bus.ready);
      end
      n_cmp++;
      if (bus.frame_err !== 1'b0) begin
         n_fail++; $display("FAIL reset_frame_err got=%b want=0", bus.frame_err);
      end
      n_cmp++;
      if (bus.receive_data !== 8'h00) begin
         n_fail++; $display("FAIL reset_rx_data got=%h want=00", bus.receive_data);
      end
      n_cmp++;
      if (bus.rom_data !== 8'h00) begin
         n_fail++; $display("FAIL reset_rom_data got=%h want=00", bus.rom_data);
      end
      n_cmp++;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      if (bus.rom_data !== 8'h30) begin
         n_fail++; $display("FAIL release_rom_data got=%h want=30", bus.rom_data);
      end
      n_cmp++;
   endtask

   task automatic test_fetch_wrap();
      int a;
      a = 0;
      for (int p = 0; p < 33; p++) begin
         @(negedge clk);
         bus.next = 1'b1;
         @(negedge clk);
         bus.next = 1'b0;
         a = (a + 1) % DEPTH;
         if (bus.addr !== 5'(a)) begin
            n_fail++; $display("FAIL fetch_addr pulse=%0d got=%0d want=%0d", p, bus.addr, a);
         end
         n_cmp++;
         @(posedge clk);
         #1;
         if (bus.rom_data !== 8'(8'h30 + a)) begin
            n_fail++;
            $display("FAIL fetch_rom pulse=%0d got=%h want=%h", p, bus.rom_data, 8'(8'h30 + a));
         end
         n_cmp++;
      end
   endtask

   // Random next pattern including held-high runs; rom_data lags addr by one edge
   task automatic test_fetch_random();
      int a, prev;
      @(negedge clk);
      a = int'(bus.addr);
      for (int c = 0; c < 60; c++) begin
         bus.next = (c >= 20 && c < 28) ? 1'b1 : 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         prev = a;
         if (bus.next) a = (a + 1) % DEPTH;
         if (bus.addr !== 5'(a)) begin
            n_fail++; $display("FAIL rand_addr cyc=%0d got=%0d want=%0d", c, bus.addr, a);
         end
         n_cmp++;
         if (bus.rom_data !== 8'(8'h30 + prev)) begin
            n_fail++;
            $display("FAIL rand_rom cyc=%0d got=%h want=%h", c, bus.rom_data, 8'(8'h30 + prev));
         end
         n_cmp++;
         @(negedge clk);
      end
      bus.next = 1'b0;
   endtask

   task automatic test_back_to_back();
      int e0a, e0b;
      clear_log();
      idle(4);
      send_frame(8'hA5, 1'b1, e0a);
      send_frame(8'h3C, 1'b1, e0b);
      idle(10);
      if (rdy_cyc.size() !== 2) begin
         n_fail++; $display("FAIL b2b_ready_count got=%0d want=2", rdy_cyc.size());
      end
      n_cmp++;
      if (rdy_cyc.size() >= 1) begin
         if (rdy_cyc[0] !== e0a + STROBE_OFS) begin
            n_fail++; $display("FAIL a5_timing got=%0d want=%0d", rdy_cyc[0], e0a + STROBE_OFS);
         end
         n_cmp++;
         if (rdy_dat[0] !== 8'hA5) begin
            n_fail++; $display("FAIL a5_data got=%h want=a5", rdy_dat[0]);
         end
         n_cmp++;
      end
      if (rdy_cyc.size() >= 2) begin
         if (rdy_cyc[1] !== e0b + STROBE_OFS) begin
            n_fail++; $display("FAIL 3c_timing got=%0d want=%0d", rdy_cyc[1], e0b + STROBE_OFS);
         end
         n_cmp++;
      end
      if (bus.receive_data !== 8'h3C) begin
         n_fail++; $display("FAIL 3c_data got=%h want=3c", bus.receive_data);
      end
      n_cmp++;
      if (ferr_cyc.size() !== 0) begin
         n_fail++; $display("FAIL b2b_frame_err got=%0d want=0", ferr_cyc.size());
      end
      n_cmp++;
   endtask

   task automatic test_frame_error();
      int e0;
      clear_log();
      send_frame(8'h5A, 1'b0, e0);
      idle(12);
      if (ferr_cyc.size() !== 1) begin
         n_fail++; $display("FAIL ferr_count got=%0d want=1", ferr_cyc.size());
      end
      n_cmp++;
      if (ferr_cyc.size() >= 1) begin
         if (ferr_cyc[0] !== e0 + STROBE_OFS) begin
            n_fail++; $display("FAIL ferr_timing got=%0d want=%0d", ferr_cyc[0], e0 + STROBE_OFS);
         end
         n_cmp++;
      end
      if (rdy_cyc.size() !== 0) begin
         n_fail++; $display("FAIL ferr_ready got=%0d want=0", rdy_cyc.size());
      end
      n_cmp++;
      if (bus.receive_data !== 8'h3C) begin
         n_fail++; $display("FAIL ferr_keep_data got=%h want=3c", bus.receive_data);
      end
      n_cmp++;
   endtask

   task automatic test_glitch();
      int e0;
      clear_log();
      @(negedge clk);
      bus.line = 1'b0;
      @(negedge clk);
      bus.line = 1'b1;
      repeat (20) @(posedge clk);
      if (rdy_cyc.size() + ferr_cyc.size() !== 0) begin
         n_fail++;
         $display("FAIL glitch_strobes got=%0d want=0", rdy_cyc.size() + ferr_cyc.size());
      end
      n_cmp++;
      // Exact timing of the following frame shows the receiver was idle
      send_frame(8'h81, 1'b1, e0);
      idle(8);
      if (rdy_cyc.size() !== 1 || rdy_cyc[0] !== e0 + STROBE_OFS || rdy_dat[0] !== 8'h81) begin
         n_fail++;
         $display("FAIL glitch_next_frame count=%0d got=%h want=81 at %0d",
                  rdy_cyc.size(), bus.receive_data, e0 + STROBE_OFS);
      end
      n_cmp++;
   endtask

   task automatic test_reset_mid_frame();
      int e0;
      clear_log();
      @(negedge clk);
      bus.line = 1'b0;
      repeat (3 * CPB) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      bus.line = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(posedge clk);
      if (rdy_cyc.size() + ferr_cyc.size() !== 0) begin
         n_fail++;
         $display("FAIL rstmid_strobes got=%0d want=0", rdy_cyc.size() + ferr_cyc.size());
      end
      n_cmp++;
      if (bus.receive_data !== 8'h00) begin
         n_fail++; $display("FAIL rstmid_data got=%h want=00", bus.receive_data);
      end
      n_cmp++;
      send_frame(8'h30, 1'b1, e0);
      idle(8);
      if (rdy_cyc.size() !== 1 || rdy_cyc[0] !== e0 + STROBE_OFS) begin
         n_fail++; $display("FAIL rstmid_next_ready count=%0d want=1", rdy_cyc.size());
      end
      n_cmp++;
      if (bus.receive_data !== 8'h30) begin
         n_fail++; $display("FAIL rstmid_next_data got=%h want=30", bus.receive_data);
      end
      n_cmp++;
   endtask

   // Random bytes and stop bits checked against a last-good-byte model
   task automatic test_random_frames();
      logic [7:0] model_data, d;
      logic       stop;
      int         e0;
      model_data = bus.receive_data;
      for (int f = 0; f < 12; f++) begin
         clear_log();
         d    = 8'($urandom);
         stop = ($urandom_range(0, 4) != 0);
         send_frame(d, stop, e0);
         idle($urandom_range(6, 12));
         if (stop) model_data = d;
         if (rdy_cyc.size() !== int'(stop) || ferr_cyc.size() !== int'(!stop)) begin
            n_fail++;
            $display("FAIL rand_strobes f=%0d ready=%0d ferr=%0d stop=%b",
                     f, rdy_cyc.size(), ferr_cyc.size(), stop);
         end
         n_cmp++;
         if (stop && rdy_cyc.size() == 1 && rdy_cyc[0] !== e0 + STROBE_OFS) begin
            n_fail++;
            $display("FAIL rand_timing f=%0d got=%0d want=%0d", f, rdy_cyc[0], e0 + STROBE_OFS);
         end
         if (stop) n_cmp++;
         if (bus.receive_data !== model_data) begin
            n_fail++;
            $display("FAIL rand_data f=%0d got=%h want=%h", f, bus.receive_data, model_data);
         end
         n_cmp++;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      bus.line = 1'b1;
      bus.next = 1'b0;
      test_reset();
      test_fetch_wrap();
      test_fetch_random();
      test_back_to_back();
      test_frame_error();
      test_glitch();
      test_reset_mid_frame();
      test_random_frames();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
